// File: rtl/mac_pkg.sv
// Shared MAC definitions: FSM state encoding and preamble/SFD constants.
// The receive side (mac_rx) imports the same package.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_IPG      = 3'd4
    } mac_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PREAMBLE_LEN  = 7;

    // Width of the phase (preamble/IPG) and post-SFD byte counters.
    localparam int unsigned CNT_W = 12;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pick is combinational from the requests
// and the pointer; the pointer only moves when the owning frame ends, and
// then points at the requester that did not own the path.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    input  logic       done,
    output logic [1:0] pick
);

    logic ptr_q, ptr_d;
    logic owner_q, owner_d;

    // Contention resolves by the pointer; a lone request always wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Remember who owns the path and flip the pointer away from them at frame end.
    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (take) begin
            owner_d = pick[1];
        end
        if (done) begin
            ptr_d = ~owner_q;
        end
    end

    // Pointer and owner registers; pointer favours requester 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Two-requester MII transmit arbiter: grants one requester, frames its bytes
// with preamble and SFD, flags aborts on txer and enforces the inter-packet gap.
// Outputs are registered together with the next state, so the driven byte
// always matches the state it belongs to. The gap seen on txen between
// back-to-back frames is the IPG state plus the single IDLE cycle, which is
// why IPG itself counts IPG_BYTES cycles including the trailing-byte cycle.
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned IPG_BYTES = 12,
    parameter int unsigned MAX_LEN   = 1518
) (
    input  logic       in_txc,
    input  logic       in_rst_n,
    input  logic       in_req0,
    input  logic       in_req1,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic       in_valid0,
    input  logic       in_valid1,
    input  logic       in_last0,
    input  logic       in_last1,
    output logic       out_grant0,
    output logic       out_grant1,
    output logic       out_ready0,
    output logic       out_ready1,
    output logic       out_txen,
    output logic [7:0] out_txd,
    output logic       out_txer
);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_BYTES - 1);
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(MAX_LEN);

    mac_state_e       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;
    logic [1:0]       grant_q, grant_d;
    logic             txen_q, txen_d;
    logic [7:0]       txd_q, txd_d;
    logic             txer_q, txer_d;

    logic [1:0] pick;
    logic       take, done;
    logic       ready, accept;
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;

    rr_arb2 u_arb (
        .clk   (in_txc),
        .rst_n (in_rst_n),
        .req   ({in_req1, in_req0}),
        .take  (take),
        .done  (done),
        .pick  (pick)
    );

    // Byte handshake: the owner may push while the frame is open and below MAX_LEN.
    always_comb begin
        ready      = ((state_q == ST_SFD) || (state_q == ST_DATA)) && (bytes_q != LEN_MAX);
        out_ready0 = ready & grant_q[0];
        out_ready1 = ready & grant_q[1];
        sel_valid  = grant_q[1] ? in_valid1 : (grant_q[0] & in_valid0);
        sel_last   = grant_q[1] ? in_last1  : in_last0;
        sel_data   = grant_q[1] ? in_data1  : in_data0;
        accept     = ready & sel_valid;
    end

    // Next state, counters and the output byte that goes with the next state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bytes_d = bytes_q;
        grant_d = grant_q;
        txen_d  = 1'b0;
        txd_d   = 8'h00;
        txer_d  = 1'b0;
        take    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    state_d = ST_PREAMBLE;
                    grant_d = pick;
                    take    = 1'b1;
                    phase_d = '0;
                    txen_d  = 1'b1;
                    txd_d   = PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                txen_d = 1'b1;
                if (phase_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    txd_d   = SFD_BYTE;
                    bytes_d = '0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                    txd_d   = PREAMBLE_BYTE;
                end
            end
            ST_SFD, ST_DATA: begin
                txen_d  = 1'b1;
                if (accept) begin
                    txd_d   = sel_data;
                    bytes_d = bytes_q + CNT_W'(1);
                    state_d = ST_DATA;
                    if (sel_last) begin
                        state_d = ST_IPG;
                        grant_d = 2'b00;
                        done    = 1'b1;
                        phase_d = '0;
                    end
                end else begin
                    // Underrun, or MAX_LEN reached without last: abort the frame.
                    txer_d  = 1'b1;
                    state_d = ST_IPG;
                    grant_d = 2'b00;
                    done    = 1'b1;
                    phase_d = '0;
                end
            end
            ST_IPG: begin
                if (phase_q == IPG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // FSM, counters and registered MII/grant outputs.
    always_ff @(posedge in_txc) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bytes_q <= '0;
            grant_q <= 2'b00;
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            txer_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bytes_q <= bytes_d;
            grant_q <= grant_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            txer_q  <= txer_d;
        end
    end

    assign out_grant0 = grant_q[0];
    assign out_grant1 = grant_q[1];
    assign out_txen   = txen_q;
    assign out_txd    = txd_q;
    assign out_txer   = txer_q;

endmodule
